// File: rtl/editor_campos_bcd.sv
// Six-field BCD date/time editor: one-step edits on button edges, bulk load, write-back over req/ack.
// Steps visible 1 cycle after the edge; write-back takes >=2 cycles per field, stalling on wr_ack.
module editor_campos_bcd #(
    parameter int NUM_CAMPOS = 6,
    parameter int IDX_W      = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IDX_W-1:0] c_2,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [47:0]      rd_data,
    input  logic             commit,
    output logic             wr_req,
    input  logic             wr_ack,
    output logic [IDX_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy,
    output logic             done,
    output logic [7:0]       campo_val
);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_ACK} state_t;

    state_t           state_q, state_d;
    logic [7:0]       campo_q [NUM_CAMPOS];
    logic             up_q, down_q;
    logic             up_edge, down_edge;
    logic             sel_ok, step_en, last_field;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       idx_val;

    function automatic logic [7:0] lim_min(input int k);
        return (k == 3 || k == 4) ? 8'h01 : 8'h00;
    endfunction

    function automatic logic [7:0] lim_max(input int k);
        case (k)
            0, 1:    return 8'h59;
            2:       return 8'h23;
            3:       return 8'h31;
            4:       return 8'h12;
            default: return 8'h99;
        endcase
    endfunction

    // Out-of-range or non-BCD contents snap to the field minimum on any step.
    function automatic logic [7:0] step_val(input logic [7:0] v, input int k, input logic inc);
        logic ok;
        ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lim_min(k)) && (v <= lim_max(k));
        if (!ok)
            return lim_min(k);
        if (inc) begin
            if (v == lim_max(k)) return lim_min(k);
            if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
            return {v[7:4], v[3:0] + 4'd1};
        end
        if (v == lim_min(k)) return lim_max(k);
        if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign up_edge    = up & ~up_q;
    assign down_edge  = down & ~down_q;
    assign sel_ok     = c_2 < IDX_W'(NUM_CAMPOS);
    assign step_en    = (state_q == IDLE) && en && sel_ok && (up_edge ^ down_edge) && !load && !commit;
    assign last_field = idx_q == IDX_W'(NUM_CAMPOS - 1);
    assign busy       = (state_q == WRITE) || (state_q == WAIT_ACK);

    always_comb begin
        campo_val = 8'h00;
        idx_val   = 8'h00;
        for (int k = 0; k < NUM_CAMPOS; k++) begin
            if (c_2 == IDX_W'(k))   campo_val = campo_q[k];
            if (idx_q == IDX_W'(k)) idx_val   = campo_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (commit && !load) state_d = WRITE;
            WRITE:    state_d = WAIT_ACK;
            WAIT_ACK: if (wr_ack) state_d = last_field ? IDLE : WRITE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CAMPOS; k++) campo_q[k] <= lim_min(k);
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            idx_q   <= '0;
            wr_req  <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
            done    <= 1'b0;
        end else begin
            up_q   <= up;
            down_q <= down;
            done   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        for (int k = 0; k < NUM_CAMPOS; k++) campo_q[k] <= rd_data[8*k +: 8];
                    end else if (commit) begin
                        idx_q <= '0;
                    end else if (step_en) begin
                        for (int k = 0; k < NUM_CAMPOS; k++)
                            if (c_2 == IDX_W'(k)) campo_q[k] <= step_val(campo_q[k], k, up_edge);
                    end
                end
                WRITE: begin
                    wr_req  <= 1'b1;
                    wr_addr <= idx_q;
                    wr_data <= idx_val;
                end
                WAIT_ACK: begin
                    if (wr_ack) begin
                        wr_req <= 1'b0;
                        if (last_field) done  <= 1'b1;
                        else            idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_editor_campos_bcd.sv
// Bench for editor_campos_bcd: decimal-arithmetic field model, per-cycle campo_val/idle compare, directed write-back checks.
module tb_editor_campos_bcd;

    logic        clk = 0, rst = 0, en = 0, up = 0, down = 0, load = 0, commit = 0, wr_ack = 0;
    logic [6:0]  c_2 = 0;
    logic [47:0] rd_data = 0;
    logic        wr_req, busy, done;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data, campo_val;

    int n_vec = 0, n_err = 0, done_cnt = 0;
    bit chk_on = 0, in_write = 0;
    logic [7:0] m [6];
    int ack_dly [6];
    int lo_t [6] = '{0, 0, 0, 1, 1, 0};
    int hi_t [6] = '{59, 59, 23, 31, 12, 99};
    logic [7:0] rst_lit [6] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};

    editor_campos_bcd dut (
        .clk(clk), .rst(rst), .en(en), .c_2(c_2), .up(up), .down(down),
        .load(load), .rd_data(rd_data), .commit(commit),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .campo_val(campo_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    function automatic logic [7:0] m_step(input int k, input logic [7:0] v, input bit inc);
        int n;
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return to_bcd(lo_t[k]);
        n = int'(v[7:4]) * 10 + int'(v[3:0]);
        if (n < lo_t[k] || n > hi_t[k]) return to_bcd(lo_t[k]);
        if (inc) n = (n == hi_t[k]) ? lo_t[k] : n + 1;
        else     n = (n == lo_t[k]) ? hi_t[k] : n - 1;
        return to_bcd(n);
    endfunction

    function automatic logic [7:0] model_val(input logic [6:0] s);
        return (s < 7'd6) ? m[s[2:0]] : 8'h00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) m[k] = rst_lit[k];
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("campo_val", campo_val, model_val(c_2));
            if (!in_write) begin
                check("idle_wr_req", wr_req, 0);
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = up, 1 = down, 2 = both together
    task automatic press(input logic [6:0] sel, input int kind);
        c_2  = sel;
        up   = (kind != 1);
        down = (kind != 0);
        tick();
        if (en && sel < 7'd6 && kind != 2) m[sel[2:0]] = m_step(int'(sel), m[sel[2:0]], kind == 0);
        up   = 0;
        down = 0;
        tick();
    endtask

    task automatic do_load(input logic [47:0] v);
        rd_data = v;
        load = 1;
        tick();
        for (int k = 0; k < 6; k++) m[k] = v[8*k +: 8];
        load = 0;
    endtask

    task automatic sweep();
        for (int s = 0; s < 7; s++) begin
            c_2 = 7'(s);
            tick();
        end
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (wr_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
    endtask

    task automatic do_commit();
        int d0;
        d0 = done_cnt;
        in_write = 1;
        commit = 1;
        tick();
        commit = 0;
        for (int f = 0; f < 6; f++) begin
            if (f == 3) begin
                wr_ack = 1;   // stray ack in the gap between fields
                tick();
                wr_ack = 0;
            end
            wait_req();
            check("wr_req_rise", wr_req, 1);
            check("wr_addr", wr_addr, f);
            check("wr_data", wr_data, m[f]);
            check("busy_in_write", busy, 1);
            for (int j = 0; j < ack_dly[f]; j++) begin
                if (f == 1 && j == 0) begin
                    c_2 = 0; up = 1; load = 1; commit = 1; rd_data = 48'hFFFF_FFFF_FFFF;
                end
                tick();
                up = 0; load = 0; commit = 0;
                check("hold_wr_req", wr_req, 1);
                check("hold_wr_addr", wr_addr, f);
                check("hold_wr_data", wr_data, m[f]);
            end
            wr_ack = 1;
            tick();
            wr_ack = 0;
            check("wr_req_drop", wr_req, 0);
            if (f == 5) begin
                check("done_pulse", done, 1);
                check("busy_end", busy, 0);
            end else begin
                check("busy_gap", busy, 1);
            end
        end
        tick();
        check("done_single", done, 0);
        in_write = 0;
        check("done_count", done_cnt, d0 + 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        model_reset();
        repeat (2) tick();
        chk_on = 1;
        for (int s = 0; s < 6; s++) begin
            c_2 = 7'(s);
            #1;
            check("reset_field", campo_val, rst_lit[s]);
        end
        check("reset_wr_req", wr_req, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_wr_data", wr_data, 0);
        rst = 1;
        tick();

        // seconds ramp through 59 and wrap
        en = 1;
        for (int i = 1; i <= 60; i++) begin
            press(0, 0);
            if (i == 59) check("sec_59", campo_val, 8'h59);
        end
        check("sec_wrap", campo_val, 8'h00);

        press(3, 1);
        check("day_wrap_down", campo_val, 8'h31);
        press(4, 1);
        check("month_wrap_down", campo_val, 8'h12);
        press(4, 0);
        check("month_wrap_up", campo_val, 8'h01);

        do_load(48'h99_12_31_23_59_59);
        for (int k = 0; k < 6; k++) begin
            press(7'(k), 0);
            check("max_up_to_min", campo_val, rst_lit[k]);
        end
        press(2, 2);
        check("both_no_change", campo_val, 8'h00);

        do_load(48'h00_13_00_24_60_5A);
        press(0, 1);
        check("invalid_sec", campo_val, 8'h00);
        press(1, 0);
        check("invalid_min", campo_val, 8'h00);
        press(4, 1);
        check("invalid_month", campo_val, 8'h01);
        press(3, 0);
        check("invalid_day", campo_val, 8'h01);
        sweep();

        // button held across enable rising must not step
        en = 0; c_2 = 1; up = 1;
        repeat (3) tick();
        en = 1;
        repeat (3) tick();
        up = 0;
        tick();
        check("held_no_step", campo_val, 8'h00);
        press(7, 0);
        check("sel_out_of_range", campo_val, 8'h00);
        sweep();

        // load wins over commit
        rd_data = 48'h25_07_14_09_30_45;
        load = 1; commit = 1;
        tick();
        for (int k = 0; k < 6; k++) m[k] = rd_data[8*k +: 8];
        load = 0; commit = 0;
        tick();
        check("load_over_commit", busy, 0);
        c_2 = 5;
        #1;
        check("loaded_year", campo_val, 8'h25);

        ack_dly = '{0, 3, 1, 5, 0, 2};
        do_commit();
        sweep();

        // reset while waiting for the ack of field 2
        d0 = done_cnt;
        in_write = 1;
        commit = 1;
        tick();
        commit = 0;
        for (int f = 0; f < 2; f++) begin
            wait_req();
            wr_ack = 1;
            tick();
            wr_ack = 0;
        end
        wait_req();
        check("abort_addr", wr_addr, 2);
        tick();
        #2;
        rst = 0;
        model_reset();
        #1;
        check("abort_wr_req", wr_req, 0);
        check("abort_busy", busy, 0);
        in_write = 0;
        repeat (2) tick();
        rst = 1;
        repeat (3) tick();
        check("abort_no_done", done_cnt, d0);
        sweep();

        press(3, 0);
        check("post_reset_step", campo_val, 8'h02);
        ack_dly = '{1, 1, 1, 1, 1, 1};
        do_commit();
        sweep();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
